// File: rtl/fpu_pkg.sv
// Shared FPU definitions: divide/sqrt FSM states and exponent bias helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_t;

    // IEEE-style exponent bias for an exponent field of exp_w bits.
    function automatic int fpu_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fpu_divsqrt_iter_if.sv
// Request/result bundle of the iterative divide/sqrt unit.
// Latency: n/a (wires only).
// Backpressure: none; requester watches busy and waits for the rdy pulse.
interface fpu_divsqrt_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                    start;
    logic                    kill;
    logic                    op_sqrt;
    logic [EXP_W-1:0]        exp_a;
    logic [EXP_W-1:0]        exp_b;
    logic [MAN_W:0]          sig_a;
    logic [MAN_W:0]          sig_b;
    logic [MAN_W+3:0]        q_sig;
    logic signed [EXP_W+1:0] q_exp;
    logic                    busy;
    logic                    rdy;
    logic                    of;
    logic                    uf;
    logic                    dz;

    modport master (
        output start, kill, op_sqrt, exp_a, exp_b, sig_a, sig_b,
        input  q_sig, q_exp, busy, rdy, of, uf, dz
    );

    modport slave (
        input  start, kill, op_sqrt, exp_a, exp_b, sig_a, sig_b,
        output q_sig, q_exp, busy, rdy, of, uf, dz
    );

endinterface

// File: rtl/lzc_n.sv
// Leading-zero counter; an all-zero input reports WIDTH.
// Latency: combinational.
// Backpressure: n/a.
module lzc_n #(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] cnt
);

    // Scan upward so the highest set bit makes the last (winning) assignment.
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) begin
                cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_divsqrt_iter.sv
// Iterative restoring divide / square-root of significands, one result bit per cycle.
// Latency: MAN_W+5 cycles from accepted start to the rdy pulse.
// Backpressure: start ignored while busy; kill aborts and returns to idle next cycle.
module fpu_divsqrt_iter
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              reset,
    fpu_divsqrt_iter_if.slave io
);

    localparam int SIG_W = MAN_W + 1;          // significand incl. hidden bit
    localparam int Q_W   = MAN_W + 3;          // hidden + fraction + guard + round
    localparam int REM_W = MAN_W + 6;          // wide enough for the sqrt remainder
    localparam int RAD_W = 2 * Q_W;            // radicand bits, two consumed per step
    localparam int XE_W  = EXP_W + 2;
    localparam int LZ_W  = $clog2(SIG_W + 1);
    localparam int CNT_W = $clog2(Q_W + 1);

    localparam logic [CNT_W-1:0]        LAST_ITER = CNT_W'(Q_W - 1);
    localparam logic signed [XE_W-1:0]  BIAS_X    = XE_W'(fpu_bias(EXP_W));
    localparam logic signed [XE_W-1:0]  EMAX_X    = XE_W'((1 << EXP_W) - 2);
    localparam logic signed [XE_W-1:0]  ONE_X     = XE_W'(1);
    localparam logic signed [XE_W-1:0]  ZERO_X    = '0;
    localparam logic [EXP_W-1:0]        EXP_ONE   = EXP_W'(1);

    fsm_state_t              state;
    logic                    op_r;
    logic [EXP_W-1:0]        ea_r, eb_r;
    logic [SIG_W-1:0]        sa_r, sb_r;
    logic [SIG_W-1:0]        dvs_r;
    logic [REM_W-1:0]        rem_r;
    logic [RAD_W-1:0]        rad_r;
    logic [Q_W-1:0]          q_r;
    logic signed [XE_W-1:0]  qe_r;
    logic                    za_r, zb_r;
    logic [CNT_W-1:0]        cnt_r;

    logic [MAN_W+3:0]        q_sig_r;
    logic signed [XE_W-1:0]  q_exp_r;
    logic                    busy_r, rdy_r, of_r, uf_r, dz_r;

    logic [LZ_W-1:0]         lz_a, lz_b;

    lzc_n #(.WIDTH(SIG_W)) u_lzc_a (.din(sa_r), .cnt(lz_a));
    lzc_n #(.WIDTH(SIG_W)) u_lzc_b (.din(sb_r), .cnt(lz_b));

    // Normalisation and result-exponent prediction from the captured operands.
    logic [SIG_W-1:0]        na, nb;
    logic [EXP_W-1:0]        ea_max, eb_max;
    logic signed [XE_W-1:0]  ea_eff, eb_eff, e_un, e_even, exp_div, exp_sq;
    logic                    a_lt_b, e_odd;
    logic [SIG_W:0]          a_div, a_sq;

    // Left-justify both significands and derive the per-mode start values.
    always_comb begin
        na      = sa_r << lz_a;
        nb      = sb_r << lz_b;
        ea_max  = (ea_r == '0) ? EXP_ONE : ea_r;
        eb_max  = (eb_r == '0) ? EXP_ONE : eb_r;
        ea_eff  = $signed({2'b00, ea_max}) - $signed({{(XE_W-LZ_W){1'b0}}, lz_a});
        eb_eff  = $signed({2'b00, eb_max}) - $signed({{(XE_W-LZ_W){1'b0}}, lz_b});

        // Divide: keep the quotient in [1,2) by pre-doubling A when A < B.
        a_lt_b  = na < nb;
        a_div   = a_lt_b ? {na, 1'b0} : {1'b0, na};
        exp_div = ea_eff - eb_eff + BIAS_X - (a_lt_b ? ONE_X : ZERO_X);

        // Sqrt: make the unbiased exponent even so it halves exactly.
        e_un    = ea_eff - BIAS_X;
        e_odd   = e_un[0];
        a_sq    = e_odd ? {na, 1'b0} : {1'b0, na};
        e_even  = e_odd ? (e_un - ONE_X) : e_un;
        exp_sq  = (e_even >>> 1) + BIAS_X;
    end

    // Shared restoring shift/subtract step; the latched op selects the operand shapes.
    logic [REM_W-1:0] partial, subtr, diff, rem_next;
    logic             ge;
    logic [Q_W-1:0]   q_next;

    // One recurrence step: trial subtract, keep on success, emit the result bit.
    always_comb begin
        if (op_r) begin
            partial = {rem_r[REM_W-3:0], rad_r[RAD_W-1 -: 2]};
            subtr   = REM_W'({q_r, 2'b01});
        end else begin
            partial = rem_r;
            subtr   = REM_W'(dvs_r);
        end
        ge       = partial >= subtr;
        diff     = ge ? (partial - subtr) : partial;
        rem_next = op_r ? diff : (diff << 1);
        q_next   = {q_r[Q_W-2:0], ge};
    end

    // Control FSM plus datapath registers; results load only on the step into DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_r    <= 1'b0;
            ea_r    <= '0;
            eb_r    <= '0;
            sa_r    <= '0;
            sb_r    <= '0;
            dvs_r   <= '0;
            rem_r   <= '0;
            rad_r   <= '0;
            q_r     <= '0;
            qe_r    <= '0;
            za_r    <= 1'b0;
            zb_r    <= 1'b0;
            cnt_r   <= '0;
            q_sig_r <= '0;
            q_exp_r <= '0;
            busy_r  <= 1'b0;
            rdy_r   <= 1'b0;
            of_r    <= 1'b0;
            uf_r    <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            rdy_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (io.start && !io.kill) begin
                        op_r   <= io.op_sqrt;
                        ea_r   <= io.exp_a;
                        eb_r   <= io.exp_b;
                        sa_r   <= io.sig_a;
                        sb_r   <= io.sig_b;
                        busy_r <= 1'b1;
                        state  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (io.kill) begin
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        za_r  <= (sa_r == '0);
                        zb_r  <= !op_r && (sb_r == '0);
                        dvs_r <= nb;
                        q_r   <= '0;
                        cnt_r <= '0;
                        if (op_r) begin
                            rem_r <= '0;
                            rad_r <= {a_sq, {(RAD_W-SIG_W-1){1'b0}}};
                            qe_r  <= exp_sq;
                        end else begin
                            rem_r <= REM_W'(a_div);
                            rad_r <= '0;
                            qe_r  <= exp_div;
                        end
                        state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (io.kill) begin
                        busy_r <= 1'b0;
                        cnt_r  <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        rem_r <= rem_next;
                        q_r   <= q_next;
                        rad_r <= rad_r << 2;
                        if (cnt_r == LAST_ITER) begin
                            cnt_r <= '0;
                            rdy_r <= 1'b1;
                            state <= ST_DONE;
                            if (zb_r) begin
                                q_sig_r <= '0;
                                q_exp_r <= '0;
                                dz_r    <= 1'b1;
                                of_r    <= 1'b0;
                                uf_r    <= 1'b0;
                            end else if (za_r) begin
                                q_sig_r <= '0;
                                q_exp_r <= '0;
                                dz_r    <= 1'b0;
                                of_r    <= 1'b0;
                                uf_r    <= 1'b0;
                            end else begin
                                q_sig_r <= {q_next, |rem_next};
                                q_exp_r <= qe_r;
                                dz_r    <= 1'b0;
                                of_r    <= qe_r > EMAX_X;
                                uf_r    <= qe_r < ONE_X;
                            end
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign io.q_sig = q_sig_r;
    assign io.q_exp = q_exp_r;
    assign io.busy  = busy_r;
    assign io.rdy   = rdy_r;
    assign io.of    = of_r;
    assign io.uf    = uf_r;
    assign io.dz    = dz_r;

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Directed bench for the iterative divide/sqrt unit with hand-computed results.
// Latency: checks the start-to-rdy cycle count on every operation.
// Backpressure: exercises start-while-busy, kill, kill+start and mid-op reset.
module tb_fpu_divsqrt_iter;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fpu_divsqrt_iter_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut_if ();

    fpu_divsqrt_iter #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (dut_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one operation in the cycle after the call; return cycles until rdy and busy after accept.
    task automatic run_op(input logic sq, input logic [7:0] ea, input logic [7:0] eb,
                          input logic [23:0] sa, input logic [23:0] sb, input bit poke,
                          output int lat, output logic busy1);
        @(posedge clk); #1;
        dut_if.op_sqrt = sq;
        dut_if.exp_a   = ea;
        dut_if.exp_b   = eb;
        dut_if.sig_a   = sa;
        dut_if.sig_b   = sb;
        dut_if.start   = 1'b1;
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        lat   = 1;
        busy1 = dut_if.busy;
        while (dut_if.rdy !== 1'b1 && lat < 64) begin
            if (poke && lat == 6) begin
                dut_if.start   = 1'b1;
                dut_if.sig_a   = 24'h123456;
                dut_if.op_sqrt = ~sq;
            end else if (poke && lat == 7) begin
                dut_if.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        dut_if.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic busy1;
        bit   rdy_seen;

        dut_if.start   = 1'b0;
        dut_if.kill    = 1'b0;
        dut_if.op_sqrt = 1'b0;
        dut_if.exp_a   = '0;
        dut_if.exp_b   = '0;
        dut_if.sig_a   = '0;
        dut_if.sig_b   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_q_sig", 64'(dut_if.q_sig), 64'h0);
        check_eq("rst_q_exp", 64'($unsigned(dut_if.q_exp)), 64'h0);
        check_eq("rst_busy",  64'(dut_if.busy), 64'h0);
        check_eq("rst_rdy",   64'(dut_if.rdy), 64'h0);
        check_eq("rst_flags", 64'({dut_if.of, dut_if.uf, dut_if.dz}), 64'h0);
        reset = 1'b0;

        // 1.0 / 1.0
        run_op(1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, 1'b0, lat, busy1);
        check_eq("d11_lat",   64'(lat), 64'd28);
        check_eq("d11_busy",  64'(busy1), 64'h1);
        check_eq("d11_sig",   64'(dut_if.q_sig), 64'h4000000);
        check_eq("d11_exp",   64'($unsigned(dut_if.q_exp)), 64'd127);
        check_eq("d11_flags", 64'({dut_if.of, dut_if.uf, dut_if.dz}), 64'h0);

        // 1.0 / 3.0 issued back-to-back, with a start pulse while busy
        run_op(1'b0, 8'd127, 8'd128, 24'h800000, 24'hC00000, 1'b1, lat, busy1);
        check_eq("d13_lat", 64'(lat), 64'd28);
        check_eq("d13_sig", 64'(dut_if.q_sig), 64'h5555555);
        check_eq("d13_exp", 64'($unsigned(dut_if.q_exp)), 64'd125);
        @(posedge clk); #1;
        check_eq("d13_idle_busy", 64'(dut_if.busy), 64'h0);
        check_eq("d13_hold_sig",  64'(dut_if.q_sig), 64'h5555555);

        // sqrt 4.0
        run_op(1'b1, 8'd129, 8'd0, 24'h800000, 24'h000000, 1'b0, lat, busy1);
        check_eq("s4_lat",   64'(lat), 64'd28);
        check_eq("s4_sig",   64'(dut_if.q_sig), 64'h4000000);
        check_eq("s4_exp",   64'($unsigned(dut_if.q_exp)), 64'd128);
        check_eq("s4_flags", 64'({dut_if.of, dut_if.uf, dut_if.dz}), 64'h0);

        // sqrt 2.0 = 1.0110101...
        run_op(1'b1, 8'd128, 8'd0, 24'h800000, 24'h000000, 1'b0, lat, busy1);
        check_eq("s2_top",    64'(dut_if.q_sig[26:24]), 64'h5);
        check_eq("s2_sticky", 64'(dut_if.q_sig[0]), 64'h1);
        check_eq("s2_exp",    64'($unsigned(dut_if.q_exp)), 64'd127);

        // smallest subnormal / 1.0 -> 2^-149, q_exp = -22
        run_op(1'b0, 8'd0, 8'd127, 24'h000001, 24'h800000, 1'b0, lat, busy1);
        check_eq("sub_sig", 64'(dut_if.q_sig), 64'h4000000);
        check_eq("sub_exp", 64'($unsigned(dut_if.q_exp)), 64'h3EA);
        check_eq("sub_uf",  64'(dut_if.uf), 64'h1);
        check_eq("sub_of",  64'(dut_if.of), 64'h0);

        // divide by zero
        run_op(1'b0, 8'd127, 8'd127, 24'h800000, 24'h000000, 1'b0, lat, busy1);
        check_eq("dz_lat", 64'(lat), 64'd28);
        check_eq("dz_dz",  64'(dut_if.dz), 64'h1);
        check_eq("dz_sig", 64'(dut_if.q_sig), 64'h0);
        check_eq("dz_exp", 64'($unsigned(dut_if.q_exp)), 64'h0);

        // zero dividend
        run_op(1'b0, 8'd0, 8'd127, 24'h000000, 24'h800000, 1'b0, lat, busy1);
        check_eq("za_lat",   64'(lat), 64'd28);
        check_eq("za_sig",   64'(dut_if.q_sig), 64'h0);
        check_eq("za_exp",   64'($unsigned(dut_if.q_exp)), 64'h0);
        check_eq("za_flags", 64'({dut_if.of, dut_if.uf, dut_if.dz}), 64'h0);

        // exponent boundaries: exactly 1 and exactly 254 are in range
        run_op(1'b0, 8'd1, 8'd127, 24'h800000, 24'h800000, 1'b0, lat, busy1);
        check_eq("e1_exp", 64'($unsigned(dut_if.q_exp)), 64'd1);
        check_eq("e1_uf",  64'(dut_if.uf), 64'h0);
        run_op(1'b0, 8'd254, 8'd127, 24'h800000, 24'h800000, 1'b0, lat, busy1);
        check_eq("e254_exp", 64'($unsigned(dut_if.q_exp)), 64'd254);
        check_eq("e254_of",  64'(dut_if.of), 64'h0);

        // overflow: 2^127 / 2^-126
        run_op(1'b0, 8'd254, 8'd1, 24'h800000, 24'h800000, 1'b0, lat, busy1);
        check_eq("ovf_exp", 64'($unsigned(dut_if.q_exp)), 64'd380);
        check_eq("ovf_of",  64'(dut_if.of), 64'h1);
        check_eq("ovf_sig", 64'(dut_if.q_sig), 64'h4000000);

        // kill at ITER cycle 10: no rdy, outputs keep the overflow result
        @(posedge clk); #1;
        dut_if.op_sqrt = 1'b0;
        dut_if.exp_a   = 8'd127;
        dut_if.exp_b   = 8'd128;
        dut_if.sig_a   = 24'h800000;
        dut_if.sig_b   = 24'hC00000;
        dut_if.start   = 1'b1;
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        dut_if.kill = 1'b1;
        @(posedge clk); #1;
        dut_if.kill = 1'b0;
        check_eq("kill_busy", 64'(dut_if.busy), 64'h0);
        rdy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (dut_if.rdy === 1'b1) rdy_seen = 1'b1;
        end
        check_eq("kill_no_rdy",  64'(rdy_seen), 64'h0);
        check_eq("kill_hold_sig", 64'(dut_if.q_sig), 64'h4000000);
        check_eq("kill_hold_exp", 64'($unsigned(dut_if.q_exp)), 64'd380);
        check_eq("kill_hold_of",  64'(dut_if.of), 64'h1);

        // kill and start together in IDLE: nothing starts
        dut_if.start = 1'b1;
        dut_if.kill  = 1'b1;
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        dut_if.kill  = 1'b0;
        check_eq("ks_busy", 64'(dut_if.busy), 64'h0);
        @(posedge clk); #1;
        check_eq("ks_busy2", 64'(dut_if.busy), 64'h0);

        // reset in the middle of an operation
        dut_if.start = 1'b1;
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mrst_sig",   64'(dut_if.q_sig), 64'h0);
        check_eq("mrst_exp",   64'($unsigned(dut_if.q_exp)), 64'h0);
        check_eq("mrst_busy",  64'(dut_if.busy), 64'h0);
        check_eq("mrst_rdy",   64'(dut_if.rdy), 64'h0);
        check_eq("mrst_flags", 64'({dut_if.of, dut_if.uf, dut_if.dz}), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // first start after reset release
        run_op(1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, 1'b0, lat, busy1);
        check_eq("post_lat", 64'(lat), 64'd28);
        check_eq("post_sig", 64'(dut_if.q_sig), 64'h4000000);
        check_eq("post_exp", 64'($unsigned(dut_if.q_exp)), 64'd127);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
